prbs4_checker: RTL
==================

# prbs4_checker

Serial receive-side checker for the 4-bit LFSR pseudo-random sequence (polynomial x^4+x^3+1, period 15) that the LFSR generator produces. It self-synchronises to an incoming bit stream, declares lock after a run of correct predictions, then flywheels on its own local LFSR while counting bit errors. It sits at the far end of a link driven by the LFSR generator and is used for link bring-up and BER measurement.

## Interface
- LOCK_CNT, 8: consecutive correct predictions required to declare lock (1..255)
- WIN, 15: loss-of-lock observation window in valid bits (2..255)
- LOSS_THR, 4: mismatches within one window that force loss of lock (1..WIN)
- CNT_W, 16: error counter width
- clk  in  1  system clock; all logic rising-edge
- clr  in  1  reset, synchronous, active-high
- in_valid  in  1  in_bit carries a stream bit this cycle
- in_bit  in  1  received stream bit
- cnt_clr  in  1  synchronous clear of err_cnt
- locked  out  1  checker is in LOCKED state
- err_pulse  out  1  one-cycle pulse per detected mismatch while LOCKED
- err_cnt  out  CNT_W  saturating mismatch count
- state  out  2  00 HUNT, 01 SYNC, 10 LOCKED

## Operation
- Stream rule: b[n] = b[n-3] XOR b[n-4]. Shift register s[3:0], s[0] newest; prediction p = s[3] XOR s[2].
- Only cycles with in_valid=1 advance anything; in_valid=0 holds all state.
- HUNT: shift in_bit into s; fill counter 0..4; on the 4th valid bit go to SYNC, match counter = 0.
- SYNC: compare in_bit with p; shift in_bit into s (received data reseeds). Match → match counter +1; mismatch → match counter = 0, stay SYNC. If s (after shift) is 0000, match counter = 0 (all-zero stream never locks). Match counter reaching LOCK_CNT → LOCKED; window and window-error counters = 0.
- LOCKED: shift p (not in_bit) into s. Mismatch → err_pulse, err_cnt +1 (saturates at all-ones), window-error +1. Window counter counts valid bits 0..WIN-1; at WIN-1 both window counters reset to 0.
- Loss of lock: window-error reaching LOSS_THR → HUNT, fill counter = 0 (see Configuration). If that bit is also the last bit of the window, loss wins.
- cnt_clr: err_cnt = 0 next cycle; cnt_clr and a mismatch in the same cycle → err_cnt = 0 (clear wins), err_pulse still asserted. Does not affect state.
- err_cnt is not cleared by loss of lock.

## Timing
- All outputs registered. Reset values: state=HUNT (00), locked=0, err_pulse=0, err_cnt=0, s=0000, all internal counters 0.
- clr has priority over every other input; clr mid-lock returns to HUNT the next cycle.
- err_pulse high exactly the cycle after the valid cycle carrying the bad bit; never high outside LOCKED.
- locked rises the cycle after the valid bit that completes LOCK_CNT matches; minimum latency from first valid bit = 4 + LOCK_CNT valid bits.
- locked falls the cycle after the loss-triggering bit.
- Back-to-back valid bits every cycle supported; no throughput limit.

## Configuration
- PRBS4_CHK_RELOCK_EN defined: loss-of-lock logic as above (window counters, automatic return to HUNT).
- Not defined: window counters absent; LOCKED is held until clr; errors only counted, never cause state change.

## Test plan
- Clean stream seeded s=0001, in_valid every cycle → state 00→01 after 4 bits, locked=1 after bit 12, err_cnt stays 0 over 300 bits.
- Locked, invert one bit every 15 bits → one err_pulse per inversion, err_cnt = 20 after 300 bits, locked stays 1 (1 < LOSS_THR).
- Locked, invert 4 bits inside one window → locked=0 the cycle after 4th bad bit, state=00, err_cnt=4; clean stream resumed → relock after 12 more bits. Without macro: locked stays 1, err_cnt=4.
- All-zero input for 100 bits → state remains 01, locked never 1; in_valid toggled 50% on a clean stream → lock after 12 valid bits regardless of gaps.
- CNT_W=4, locked, 20 single errors → err_cnt saturates at 15; cnt_clr together with a mismatch → err_cnt=0, err_pulse=1.
- clr asserted while locked with errors pending → next cycle all outputs at reset values.

Source files
------------

// File: rtl/prbs4_checker_if.sv
// Receive-side stream bundle for prbs4_checker: one bit per cycle qualified by in_valid.
interface prbs4_checker_if;
  logic in_valid;
  logic in_bit;

  modport master (output in_valid, output in_bit);
  modport slave  (input  in_valid, input  in_bit);
endinterface

// File: rtl/prbs4_checker.sv
// Self-synchronising checker for the x^4+x^3+1 (period 15) PRBS stream with error counting.
// Optional macro PRBS4_CHK_RELOCK_EN adds windowed loss-of-lock with automatic return to HUNT.
module prbs4_checker #(
  parameter int LOCK_CNT = 8,
  parameter int WIN      = 15,
  parameter int LOSS_THR = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  prbs4_checker_if.slave   rx,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [7:0]       LOCK_C  = 8'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Next stream bit implied by the two oldest taps: b[n] = b[n-3] ^ b[n-4].
  function automatic logic prbs_pred(input logic [3:0] s);
    return s[3] ^ s[2];
  endfunction

  state_t           state_r;
  logic [3:0]       s_r;
  logic [2:0]       fill_r;
  logic [7:0]       match_r;
  logic             locked_r;
  logic             err_pulse_r;
  logic [CNT_W-1:0] err_cnt_r;

  logic             pred_s;
  logic             miss_s;
  logic [3:0]       s_rx_s;

`ifdef PRBS4_CHK_RELOCK_EN
  localparam logic [7:0] WIN_LAST = 8'(WIN - 1);
  localparam logic [7:0] LOSS_C   = 8'(LOSS_THR);
  logic [7:0] win_r;
  logic [7:0] werr_r;
  logic [7:0] werr_nxt_s;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{8'(WIN), 8'(LOSS_THR)};
`endif

  // Prediction, mismatch flag and the register as reseeded by received data.
  always_comb begin
    pred_s = prbs_pred(s_r);
    miss_s = rx.in_bit ^ pred_s;
    s_rx_s = {s_r[2:0], rx.in_bit};
`ifdef PRBS4_CHK_RELOCK_EN
    werr_nxt_s = werr_r + {7'd0, miss_s};
`endif
  end

  // Single state machine: hunt/sync/locked sequencing, flywheel LFSR and error counting.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r     <= HUNT;
      s_r         <= 4'b0000;
      fill_r      <= 3'd0;
      match_r     <= 8'd0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      err_cnt_r   <= {CNT_W{1'b0}};
`ifdef PRBS4_CHK_RELOCK_EN
      win_r       <= 8'd0;
      werr_r      <= 8'd0;
`endif
    end else begin
      err_pulse_r <= 1'b0;
      if (cnt_clr) err_cnt_r <= {CNT_W{1'b0}};
      if (rx.in_valid) begin
        case (state_r)
          HUNT: begin
            s_r <= s_rx_s;
            if (fill_r == 3'd3) begin
              state_r <= SYNC;
              fill_r  <= 3'd0;
              match_r <= 8'd0;
            end else begin
              fill_r <= fill_r + 3'd1;
            end
          end
          SYNC: begin
            s_r <= s_rx_s;
            // An all-zero register predicts zeros forever, so it never counts toward lock.
            if (miss_s || (s_rx_s == 4'b0000)) begin
              match_r <= 8'd0;
            end else if ((match_r + 8'd1) == LOCK_C) begin
              state_r  <= LOCKED;
              locked_r <= 1'b1;
`ifdef PRBS4_CHK_RELOCK_EN
              win_r    <= 8'd0;
              werr_r   <= 8'd0;
`endif
            end else begin
              match_r <= match_r + 8'd1;
            end
          end
          LOCKED: begin
            s_r <= {s_r[2:0], pred_s};
            if (miss_s) begin
              err_pulse_r <= 1'b1;
              if (!cnt_clr && (err_cnt_r != CNT_MAX)) err_cnt_r <= err_cnt_r + CNT_ONE;
            end
`ifdef PRBS4_CHK_RELOCK_EN
            if (werr_nxt_s == LOSS_C) begin
              state_r  <= HUNT;
              locked_r <= 1'b0;
              fill_r   <= 3'd0;
              win_r    <= 8'd0;
              werr_r   <= 8'd0;
            end else if (win_r == WIN_LAST) begin
              win_r  <= 8'd0;
              werr_r <= 8'd0;
            end else begin
              win_r  <= win_r + 8'd1;
              werr_r <= werr_nxt_s;
            end
`endif
          end
          default: begin
            state_r  <= HUNT;
            locked_r <= 1'b0;
            fill_r   <= 3'd0;
          end
        endcase
      end
    end
  end

  assign state     = state_r;
  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign err_cnt   = err_cnt_r;

endmodule
